// File: rtl/byte_sum_assembler_pkg.sv
// Shared types and sizing for the nibble-sum assembly path.
package byte_sum_assembler_pkg;

    localparam int NIB_W_DEF = 4;

    typedef enum logic [1:0] {
        S_LO  = 2'd0,
        S_HI  = 2'd1,
        S_OUT = 2'd2
    } state_e;

    function automatic int sum_width(input int nib_w);
        return 2 * nib_w + 1;
    endfunction

endpackage

// File: rtl/byte_sum_assembler.sv
// Collects low/high nibble sums, merges the low carry into the high nibble and
// presents the assembled byte sum on a registered valid/ready output.
module byte_sum_assembler
    import byte_sum_assembler_pkg::*;
#(
    parameter int NIB_W = NIB_W_DEF,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        nib_valid,
    output logic                        nib_ready,
    input  logic                        nib_hi,
    input  logic [NIB_W:0]              nib_sum,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [sum_width(NIB_W)-1:0] sum,
    output logic                        seq_err,
    output logic [CNT_W-1:0]            done_cnt
);

    localparam int SUM_W = sum_width(NIB_W);

    state_e             state_q;
    logic [NIB_W-1:0]   lo_q;
    logic               c_q;
    logic               out_valid_q;
    logic [SUM_W-1:0]   sum_q;
    logic               seq_err_q;
    logic [CNT_W-1:0]   done_cnt_q;

    logic               accept;
    logic               handoff;
    logic [NIB_W:0]     hi_add;

    // Ready depends only on state and out_ready, never on nib_valid.
    assign nib_ready = (state_q != S_OUT) | out_ready;
    assign accept    = nib_valid & nib_ready;
    assign handoff   = out_valid_q & out_ready;
    assign hi_add    = nib_sum + {{NIB_W{1'b0}}, c_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LO;
            lo_q        <= '0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            seq_err_q   <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            seq_err_q <= 1'b0;
            if (handoff) begin
                out_valid_q <= 1'b0;
                done_cnt_q  <= done_cnt_q + CNT_W'(1);
            end
            case (state_q)
                S_LO: begin
                    if (accept) begin
                        if (!nib_hi) begin
                            lo_q    <= nib_sum[NIB_W-1:0];
                            c_q     <= nib_sum[NIB_W];
                            state_q <= S_HI;
                        end else begin
                            seq_err_q <= 1'b1;
                        end
                    end
                end
                S_HI: begin
                    if (accept) begin
                        if (nib_hi) begin
                            sum_q       <= {hi_add, lo_q};
                            out_valid_q <= 1'b1;
                            state_q     <= S_OUT;
                        end else begin
                            // A second low nibble replaces the first.
                            seq_err_q <= 1'b1;
                            lo_q      <= nib_sum[NIB_W-1:0];
                            c_q       <= nib_sum[NIB_W];
                        end
                    end
                end
                S_OUT: begin
                    if (handoff) begin
                        if (accept && !nib_hi) begin
                            lo_q    <= nib_sum[NIB_W-1:0];
                            c_q     <= nib_sum[NIB_W];
                            state_q <= S_HI;
                        end else begin
                            if (accept) seq_err_q <= 1'b1;
                            state_q <= S_LO;
                        end
                    end
                end
                default: state_q <= S_LO;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign seq_err   = seq_err_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_byte_sum_assembler.sv
// Directed bench for byte_sum_assembler: expected sums go into a scoreboard
// queue that a negedge monitor pops on every output handoff.
module tb_byte_sum_assembler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       nib_valid = 1'b0;
    logic       nib_ready;
    logic       nib_hi = 1'b0;
    logic [4:0] nib_sum = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] sum;
    logic       seq_err;
    logic [7:0] done_cnt;

    int tests = 0;
    int fails = 0;
    int seq_cnt = 0;
    int cyc = 0;
    logic [7:0] exp_done = '0;
    logic [8:0] sb[$];

    byte_sum_assembler #(.NIB_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .nib_valid(nib_valid), .nib_ready(nib_ready), .nib_hi(nib_hi), .nib_sum(nib_sum),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .seq_err(seq_err), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a handoff happens at the coming posedge.
    always @(negedge clk) begin
        if (rst_n && seq_err) seq_cnt++;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb_empty: got sum 0x%0h with no expected entry", sum);
            end else begin
                chk("sum", sum, sb.pop_front());
            end
            chk("done_cnt_pre", done_cnt, exp_done);
            exp_done = exp_done + 8'd1;
        end
    end

    // Drive one nibble; returns at posedge+1 after it is accepted.
    task automatic send(input logic hi, input logic [4:0] v);
        int n;
        nib_valid = 1'b1; nib_hi = hi; nib_sum = v;
        n = 0;
        forever begin
            @(negedge clk);
            if (nib_ready) break;
            n++;
            if (n > 50) begin
                tests++; fails++;
                $display("FAIL send_timeout: nib_ready 0 expected 1");
                break;
            end
        end
        @(posedge clk); #1;
        nib_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() != 0 && n < 50) begin idle(1); n++; end
        chk("drain", sb.size(), 0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_done = '0;
        seq_cnt = 0;
    endtask

    initial begin
        int c0, stalls, s0;
        logic [7:0] b;
        logic [4:0] hi5;
        idle(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_nib_ready", nib_ready, 1);
        rst_n = 1'b1;
        idle(1);

        // 1: basic pair
        sb.push_back(9'h0a5);
        send(1'b0, 5'h05);
        send(1'b1, 5'h0a);
        chk("latency_out_valid", out_valid, 1);
        idle(1);
        chk("done_cnt_1", done_cnt, 1);
        chk("out_valid_cleared", out_valid, 0);

        // 2: carry merge and max values
        sb.push_back(9'h09a);
        send(1'b0, 5'h1a);
        idle(2);                      // nib_valid=0 in S_HI changes nothing
        send(1'b1, 5'h08);
        sb.push_back(9'h1fe);
        send(1'b0, 5'h1e);
        send(1'b1, 5'h1e);
        drain();

        // 3: out-of-order nibbles
        s0 = seq_cnt;
        send(1'b1, 5'h0a);
        chk("seq_err_lo", seq_err, 1);
        chk("no_out_on_err", out_valid, 0);
        idle(1);
        chk("seq_err_one_cycle", seq_err, 0);
        sb.push_back(9'h043);
        send(1'b0, 5'h03);
        send(1'b1, 5'h04);
        sb.push_back(9'h012);
        send(1'b0, 5'h17);
        send(1'b0, 5'h02);            // replaces lo 7/c1
        chk("seq_err_hi", seq_err, 1);
        send(1'b1, 5'h01);
        drain();
        chk("seq_err_count", seq_cnt - s0, 2);

        // 4: backpressure
        out_ready = 1'b0;
        sb.push_back(9'h0a5);
        send(1'b0, 5'h05);
        send(1'b1, 5'h0a);
        c0 = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || sum !== 9'h0a5 || nib_ready !== 1'b0) c0++;
        end
        chk("backpressure_hold", c0, 0);
        @(posedge clk); #1;
        b = done_cnt;
        out_ready = 1'b1;
        sb.push_back(9'h015);
        send(1'b0, 5'h05);            // accepted on the handoff edge
        chk("bp_done_inc", done_cnt, int'(b) + 1);
        chk("bp_out_valid_low", out_valid, 0);
        send(1'b1, 5'h01);            // completes only if state went to S_HI
        chk("bp_hi_valid", out_valid, 1);
        drain();

        // 5: reset in S_HI and in S_OUT
        send(1'b0, 5'h0f);
        do_reset();
        chk("rstHI_out_valid", out_valid, 0);
        chk("rstHI_sum", sum, 0);
        chk("rstHI_done_cnt", done_cnt, 0);
        idle(1); rst_n = 1'b1; idle(1);
        out_ready = 1'b0;
        send(1'b0, 5'h03);
        send(1'b1, 5'h03);
        chk("pre_rst_valid", out_valid, 1);
        do_reset();
        chk("rstOUT_out_valid", out_valid, 0);
        chk("rstOUT_sum", sum, 0);
        chk("rstOUT_done_cnt", done_cnt, 0);
        idle(1); rst_n = 1'b1; out_ready = 1'b1; idle(1);
        send(1'b1, 5'h02);            // stale lo must be gone: this is an error
        chk("rst_lo_discarded", seq_err, 1);
        sb.push_back(9'h077);
        send(1'b0, 5'h07);
        send(1'b1, 5'h07);
        drain();
        chk("post_rst_done", done_cnt, 1);

        // 6: 256 back-to-back pairs, done_cnt wraps
        do_reset();
        idle(1); rst_n = 1'b1; idle(1);
        stalls = 0;
        c0 = cyc;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            hi5 = {1'b0, b[7:4]} + {4'd0, b[4]};
            sb.push_back({hi5, b[3:0]});
            nib_valid = 1'b1; nib_hi = 1'b0; nib_sum = b[4:0];
            @(negedge clk); if (!nib_ready) stalls++;
            @(posedge clk); #1;
            nib_hi = 1'b1; nib_sum = {1'b0, b[7:4]};
            @(negedge clk); if (!nib_ready) stalls++;
            @(posedge clk); #1;
        end
        nib_valid = 1'b0;
        chk("stream_cycles", cyc - c0, 512);
        chk("stream_stalls", stalls, 0);
        idle(2);
        chk("wrap_done_cnt", done_cnt, 0);
        chk("stream_sb_empty", sb.size(), 0);
        chk("stream_no_seq_err", seq_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
